// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared pipeline widths and MEM-stage FSM state encoding
package mem_access_stage_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory req/ack port (master=stage: req/we/addr/wdata out, ack/rdata in)
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;
  logic req;
  logic we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic ack;
  logic [DATA_W-1:0] rdata;
  modport master(output req, we, addr, wdata, input ack, rdata);
  modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage_memwb_reg.sv
// memwb_reg: MEM/WB register with bubble (i_hold) and retire-as-bubble (i_kill) controls, error flags and write-back mux
module memwb_reg
  import mem_access_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_hold,
  input  logic              i_kill,
  input  logic              i_misalign,
  input  logic              i_bus_err,
  input  logic              i_ack,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_memtoreg,
  input  logic              i_regwrite,
  input  logic [REG_W-1:0]  i_write_reg,
  output logic [DATA_W-1:0] o_read_data,
  output logic [DATA_W-1:0] o_alu,
  output logic [DATA_W-1:0] o_write_data,
  output logic              o_memtoreg,
  output logic              o_regwrite,
  output logic [REG_W-1:0]  o_write_reg,
  output logic              o_misalign,
  output logic              o_bus_err
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_read_data <= '0;
      o_alu       <= '0;
      o_memtoreg  <= 1'b0;
      o_regwrite  <= 1'b0;
      o_write_reg <= '0;
      o_misalign  <= 1'b0;
      o_bus_err   <= 1'b0;
    end else begin
      o_misalign <= i_misalign;
      o_bus_err  <= i_bus_err;
      o_regwrite <= i_regwrite & ~i_hold & ~i_kill;
      o_memtoreg <= i_memtoreg & ~i_hold & ~i_kill;
      if (!i_hold) begin
        o_alu       <= i_alu;
        o_write_reg <= i_write_reg;
        if (i_ack) o_read_data <= i_rdata;
      end
    end
  end
  assign o_write_data = o_memtoreg ? o_read_data : o_alu;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage; drives dmem req/ack port, stalls upstream, resolves branches, holds MEM/WB (_s4)
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ALU_result_s3,
  input  logic [DATA_W-1:0] read_data2_s3,
  input  logic              MemRead_s3,
  input  logic              MemWrite_s3,
  input  logic              MemtoReg_s3,
  input  logic              RegWrite_s3,
  input  logic              Branch_s3,
  input  logic              zero_s3,
  input  logic [REG_W-1:0]  write_reg_s3,
  input  logic [DATA_W-1:0] pc_out1_s3,
  mem_access_stage_if.master dmem,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] read_data_s4,
  output logic [DATA_W-1:0] ALU_result_s4,
  output logic              MemtoReg_s4,
  output logic              RegWrite_s4,
  output logic [REG_W-1:0]  write_reg_s4,
  output logic [DATA_W-1:0] write_data_s4,
  output logic              misalign_s4,
  output logic              bus_err_s4
);
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic w_mem_op, w_aligned, w_timeout_hit, w_ack, w_misalign, w_bus_err;
  assign w_mem_op      = MemRead_s3 | MemWrite_s3;
  assign w_aligned     = ALU_result_s3[1:0] == 2'b00;
  assign w_timeout_hit = (r_state == WAIT) && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign dmem.req      = reset & (((r_state == IDLE) & w_mem_op & w_aligned) | (r_state == WAIT));
  assign dmem.we       = MemWrite_s3;
  assign dmem.addr     = ALU_result_s3;
  assign dmem.wdata    = read_data2_s3;
  // an ack with no request outstanding is stale and must not complete anything
  assign w_ack         = dmem.ack & dmem.req;
  assign stall         = dmem.req & ~w_ack & ~w_timeout_hit;
  assign w_misalign    = w_mem_op & ~w_aligned;
  assign w_bus_err     = w_timeout_hit & ~w_ack;
  assign pc_src        = Branch_s3 & zero_s3 & ~stall;
  assign branch_target = pc_out1_s3;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (dmem.req & ~w_ack) begin
        r_state <= WAIT;
        r_cnt   <= '0;
      end
    end else if (w_ack | w_timeout_hit) begin
      r_state <= IDLE;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  memwb_reg u_memwb (
    .clk          (clk),
    .reset        (reset),
    .i_hold       (stall),
    .i_kill       (w_misalign | w_bus_err),
    .i_misalign   (w_misalign),
    .i_bus_err    (w_bus_err),
    .i_ack        (w_ack),
    .i_alu        (ALU_result_s3),
    .i_rdata      (dmem.rdata),
    .i_memtoreg   (MemtoReg_s3),
    .i_regwrite   (RegWrite_s3),
    .i_write_reg  (write_reg_s3),
    .o_read_data  (read_data_s4),
    .o_alu        (ALU_result_s4),
    .o_write_data (write_data_s4),
    .o_memtoreg   (MemtoReg_s4),
    .o_regwrite   (RegWrite_s4),
    .o_write_reg  (write_reg_s4),
    .o_misalign   (misalign_s4),
    .o_bus_err    (bus_err_s4)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage with TIMEOUT=4
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] alu, rd2, pc1;
  logic mrd, mwr, m2r, rw, br, zr;
  logic [4:0] wreg;
  logic stall, pc_src, m2r4, rw4, mis4, berr4;
  logic [31:0] btgt, rdat4, alu4, wdat4;
  logic [4:0] wreg4;
  int total = 0;
  int bad = 0;
  mem_access_stage_if dm();
  mem_access_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .ALU_result_s3(alu), .read_data2_s3(rd2),
    .MemRead_s3(mrd), .MemWrite_s3(mwr), .MemtoReg_s3(m2r), .RegWrite_s3(rw),
    .Branch_s3(br), .zero_s3(zr), .write_reg_s3(wreg), .pc_out1_s3(pc1),
    .dmem(dm),
    .stall(stall), .pc_src(pc_src), .branch_target(btgt),
    .read_data_s4(rdat4), .ALU_result_s4(alu4), .MemtoReg_s4(m2r4), .RegWrite_s4(rw4),
    .write_reg_s4(wreg4), .write_data_s4(wdat4), .misalign_s4(mis4), .bus_err_s4(berr4)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic nop();
    alu = 0; rd2 = 0; pc1 = 0; mrd = 0; mwr = 0; m2r = 0; rw = 0; br = 0; zr = 0; wreg = 0;
    dm.ack = 0; dm.rdata = 0;
  endtask
  initial begin
    reset = 0;
    nop();
    alu = 32'h10; mrd = 1;
    #1;
    chk("rst_req", dm.req, 0);
    tick();
    tick();
    chk("rst_wdata", wdat4, 0);
    chk("rst_rw", rw4, 0);
    chk("rst_wreg", wreg4, 0);
    reset = 1;
    nop();
    tick();
    // zero-wait load
    alu = 32'h10; mrd = 1; m2r = 1; rw = 1; wreg = 5; dm.ack = 1; dm.rdata = 32'hDEADBEEF;
    #1;
    chk("ld_req", dm.req, 1);
    chk("ld_we", dm.we, 0);
    chk("ld_addr", dm.addr, 32'h10);
    chk("ld_stall", stall, 0);
    tick();
    nop();
    #1;
    chk("ld_wdata", wdat4, 32'hDEADBEEF);
    chk("ld_rw", rw4, 1);
    chk("ld_wreg", wreg4, 5);
    // three-wait store
    alu = 32'h20; rd2 = 32'h1234; mwr = 1;
    for (int i = 0; i < 4; i++) begin
      dm.ack = (i == 3);
      #1;
      chk("st_req", dm.req, 1);
      chk("st_we", dm.we, 1);
      chk("st_addr", dm.addr, 32'h20);
      chk("st_data", dm.wdata, 32'h1234);
      chk("st_stall", stall, (i < 3) ? 1 : 0);
      tick();
      chk("st_rw", rw4, 0);
    end
    nop();
    #1;
    chk("st_done_req", dm.req, 0);
    chk("st_done_stall", stall, 0);
    // misaligned load
    alu = 32'h22; mrd = 1; m2r = 1; rw = 1; wreg = 7;
    #1;
    chk("mis_req", dm.req, 0);
    chk("mis_stall", stall, 0);
    tick();
    nop();
    #1;
    chk("mis_flag", mis4, 1);
    chk("mis_rw", rw4, 0);
    tick();
    chk("mis_clr", mis4, 0);
    // timeout with no ack
    alu = 32'h40; mrd = 1; m2r = 1; rw = 1; wreg = 9;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("to_req", dm.req, 1);
      chk("to_stall", stall, (i < 4) ? 1 : 0);
      tick();
    end
    nop();
    #1;
    chk("to_idle_req", dm.req, 0);
    chk("to_idle_stall", stall, 0);
    chk("to_berr", berr4, 1);
    chk("to_rw", rw4, 0);
    tick();
    chk("to_berr_clr", berr4, 0);
    // branch
    br = 1; zr = 1; pc1 = 32'h400;
    #1;
    chk("br_src", pc_src, 1);
    chk("br_tgt", btgt, 32'h400);
    zr = 0;
    #1;
    chk("br_nt", pc_src, 0);
    nop();
    // plain ALU op to load MEM/WB before the reset test
    alu = 32'h55; rw = 1; wreg = 3;
    tick();
    chk("alu_wdata", wdat4, 32'h55);
    chk("alu_rw", rw4, 1);
    // reset during WAIT
    nop();
    alu = 32'h80; mrd = 1; rw = 1; wreg = 4;
    tick();
    chk("hold_alu", alu4, 32'h55);
    chk("hold_wreg", wreg4, 3);
    chk("hold_rw", rw4, 0);
    tick();
    reset = 0;
    #1;
    chk("rw_req", dm.req, 0);
    chk("rw_stall", stall, 0);
    tick();
    reset = 1;
    nop();
    dm.ack = 1; dm.rdata = 32'hCAFEF00D;
    #1;
    chk("rel_alu", alu4, 0);
    chk("rel_wreg", wreg4, 0);
    chk("rel_rdata", rdat4, 0);
    chk("late_req", dm.req, 0);
    chk("late_stall", stall, 0);
    tick();
    dm.ack = 0;
    chk("late_rdata", rdat4, 0);
    chk("late_rw", rw4, 0);
    // back in IDLE: a fresh zero-wait load works normally
    alu = 32'h44; mrd = 1; m2r = 1; rw = 1; wreg = 2; dm.ack = 1; dm.rdata = 32'h0BADCAFE;
    #1;
    chk("post_stall", stall, 0);
    tick();
    nop();
    #1;
    chk("post_wdata", wdat4, 32'h0BADCAFE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
